i2s_tx_scheduler: RTL and testbench

Sequences a stereo I2S transmit link. The block generates the bit clock, the word-select line and the serial data from a pair of DATA_W-bit samples. It accepts left/right sample pairs from an upstream source through a valid/ready handshake and buffers one pair. It schedules left then right channel per frame and flags underruns. It sits between the sample source and the I2S pins, replacing free-running shift logic with a framed, flow-controlled sequencer.

---
 rtl/i2s_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_scheduler.sv
// Framed I2S transmitter: one-pair holding buffer feeds left/right active registers once per frame.
// Outputs registered; enable edge to left MSB on sdata is 1 clk. sample_ready = buffer empty, never combinational on sample_valid.
module i2s_tx_scheduler #(
   parameter int DATA_W   = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] left_data,
   input  logic [DATA_W-1:0] right_data,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              frame_start,
   output logic              underrun,
   output logic              busy
);

   localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * DATA_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_W - 1);
   localparam logic [BIT_W-1:0] LR_LO    = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] LR_HI    = BIT_W'(2 * DATA_W - 2);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic              buf_full, buf_full_nxt;
   logic [DATA_W-1:0] buf_l, buf_r, buf_l_nxt, buf_r_nxt;
   logic [DATA_W-1:0] act_l, act_r, act_l_nxt, act_r_nxt;
   logic              xfer, slot_edge, load, silent;
   logic [2*DATA_W-1:0] frame_word;

   assign sample_ready = ~buf_full;
   assign xfer         = sample_valid & ~buf_full;
   assign slot_edge    = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      bit_nxt   = bit_cnt;
      load      = 1'b0;
      case (state)
         IDLE: begin
            div_nxt = '0;
            bit_nxt = '0;
            if (enable) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            div_nxt = slot_edge ? '0 : div_cnt + 1'b1;
            if (slot_edge) begin
               bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
               // Frame boundary: either reload or retire, never mid-frame.
               if (bit_cnt == BIT_LAST) begin
                  if (enable) load = 1'b1;
                  else        state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      buf_full_nxt = buf_full;
      buf_l_nxt    = buf_l;
      buf_r_nxt    = buf_r;
      act_l_nxt    = act_l;
      act_r_nxt    = act_r;
      silent       = 1'b0;
      if (load) begin
         if (buf_full) begin
            act_l_nxt    = buf_l;
            act_r_nxt    = buf_r;
            buf_full_nxt = 1'b0;
         end else if (xfer) begin
            // Pair arriving on the load edge goes straight to the shifter.
            act_l_nxt = left_data;
            act_r_nxt = right_data;
         end else begin
            act_l_nxt = '0;
            act_r_nxt = '0;
            silent    = 1'b1;
         end
      end else if (xfer) begin
         buf_l_nxt    = left_data;
         buf_r_nxt    = right_data;
         buf_full_nxt = 1'b1;
      end
      frame_word = {act_l_nxt, act_r_nxt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         buf_full    <= 1'b0;
         buf_l       <= '0;
         buf_r       <= '0;
         act_l       <= '0;
         act_r       <= '0;
         bclk        <= 1'b0;
         lrclk       <= 1'b0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         div_cnt     <= div_nxt;
         bit_cnt     <= bit_nxt;
         buf_full    <= buf_full_nxt;
         buf_l       <= buf_l_nxt;
         buf_r       <= buf_r_nxt;
         act_l       <= act_l_nxt;
         act_r       <= act_r_nxt;
         // Pins are driven from next-state values so they line up with the counters.
         bclk        <= (state_nxt == RUN) && (div_nxt >= DIV_HALF);
         lrclk       <= (state_nxt == RUN) && (bit_nxt >= LR_LO) && (bit_nxt <= LR_HI);
         sdata       <= (state_nxt == RUN) && frame_word[BIT_LAST - bit_nxt];
         frame_start <= load;
         underrun    <= silent;
         busy        <= (state_nxt == RUN);
      end
   end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: accepted pairs are queued as expected frames, captured frames pop and compare.
module tb_i2s_tx_scheduler;

   localparam int DW    = 16;
   localparam int BD    = 4;
   localparam int FRAME = 2 * DW * BD;

   logic          clk = 1'b0;
   logic          rst_n, enable, sample_valid;
   logic [DW-1:0] left_data, right_data;
   logic          sample_ready, bclk, lrclk, sdata, frame_start, underrun, busy;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   i2s_tx_scheduler #(.DATA_W(DW), .BCLK_DIV(BD)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .left_data(left_data), .right_data(right_data),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
      .frame_start(frame_start), .underrun(underrun), .busy(busy)
   );

   task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input int max_cyc, output bit ok);
      ok = 1'b0;
      left_data = l; right_data = r; sample_valid = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         if (sample_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         sb.push_back({l, r});
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_fs(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (frame_start === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // Starts on the negedge where frame_start is high (slot 0), ends on the last clk of the frame.
   task automatic capture_frame(input int drop_slot, output logic [31:0] dat, output logic [31:0] lr,
                                output int bclk_err, output int busy_err, output int fs_cnt,
                                output int ur_cnt, output logic rdy0, output logic ur0);
      dat = '0; lr = '0; bclk_err = 0; busy_err = 0; fs_cnt = 0; ur_cnt = 0;
      rdy0 = sample_ready; ur0 = underrun;
      for (int k = 0; k < FRAME; k++) begin
         int slot;
         slot = k / BD;
         if (k % BD == 0) begin
            lr[31-slot] = lrclk;
            if (slot == drop_slot) enable = 1'b0;
         end
         if (k % BD == BD / 2) dat[31-slot] = sdata;
         if (bclk !== ((k % BD) >= BD / 2)) bclk_err++;
         if (busy !== 1'b1) busy_err++;
         if (frame_start === 1'b1) fs_cnt++;
         if (underrun === 1'b1) ur_cnt++;
         if (k < FRAME - 1) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; left_data = '0; right_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bclk, lrclk, sdata, frame_start, underrun, busy} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs got=%b exp=000000", {bclk, lrclk, sdata, frame_start, underrun, busy});
      end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sample_ready); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bclk, lrclk, sdata, busy, sample_ready} !== 5'b00001) begin
         errors++; $display("FAIL idle_after_reset got=%b exp=00001", {bclk, lrclk, sdata, busy, sample_ready});
      end
   endtask

   task automatic test_preload;
      bit ok; logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      offer(16'hA5F0, 16'h0F3C, 50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL preload_accept got=0 exp=1"); end
      checks++;
      if ({sample_ready, busy} !== 2'b00) begin errors++; $display("FAIL preload_held got=%b exp=00", {sample_ready, busy}); end
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if ({frame_start, sdata, busy} !== 3'b111) begin
         errors++; $display("FAIL start_latency got=%b exp=111", {frame_start, sdata, busy});
      end
      capture_frame(0, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp) begin errors++; $display("FAIL preload_sdata got=%h exp=%h", dat, exp); end
      checks++;
      // Slots 15..30 map to bits 16..1.
      if (lr !== 32'h0001_FFFE) begin errors++; $display("FAIL preload_lrclk got=%h exp=0001fffe", lr); end
      checks++;
      if (be !== 0) begin errors++; $display("FAIL preload_bclk got=%0d bad cycles exp=0", be); end
      checks++;
      if ({fs, ur} !== {32'd1, 32'd0}) begin errors++; $display("FAIL preload_pulses got fs=%0d ur=%0d exp fs=1 ur=0", fs, ur); end
      checks++;
      if (r0 !== 1'b1) begin errors++; $display("FAIL preload_ready_after_load got=%b exp=1", r0); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL preload_stop got busy=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back;
      bit ok; logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      logic [DW-1:0] pl[2], pr[2];
      bit got;
      pl[0] = 16'h1357; pr[0] = 16'h2468;
      pl[1] = 16'hCAFE; pr[1] = 16'hBEEF;
      offer(16'h0001, 16'h8000, 50, ok);
      fork
         begin
            sample_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
               left_data = pl[i]; right_data = pr[i]; got = 1'b0;
               for (int c = 0; c < 400; c++) begin
                  if (sample_ready === 1'b1) begin got = 1'b1; break; end
                  @(negedge clk);
               end
               checks++;
               if (!got) begin errors++; $display("FAIL b2b_accept%0d got=timeout exp=accept", i); end
               else begin
                  @(posedge clk);
                  @(negedge clk);
                  sb.push_back({pl[i], pr[i]});
                  checks++;
                  if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop%0d got=%b exp=0", i, sample_ready); end
               end
            end
            sample_valid = 1'b0;
         end
         begin
            enable = 1'b1;
            for (int f = 0; f < 3; f++) begin
               wait_fs(400, ok);
               checks++;
               if (!ok) begin errors++; $display("FAIL b2b_frame%0d got=timeout exp=frame_start", f); end
               else begin
                  capture_frame((f == 2) ? 0 : -1, dat, lr, be, bu, fs, ur, r0, u0);
                  exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
                  checks++;
                  if (dat !== exp) begin errors++; $display("FAIL b2b_sdata%0d got=%h exp=%h", f, dat, exp); end
                  checks++;
                  if ({fs, ur} !== {32'd1, 32'd0}) begin errors++; $display("FAIL b2b_pulses%0d got fs=%0d ur=%0d exp fs=1 ur=0", f, fs, ur); end
                  checks++;
                  if (r0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise%0d got=%b exp=1", f, r0); end
               end
            end
         end
      join
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b exp=0", busy); end
   endtask

   task automatic test_underrun;
      bit ok, ok2; logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      offer(16'h8001, 16'h7FFE, 50, ok);
      sb.push_back(32'h0);
      enable = 1'b1;
      @(negedge clk);
      capture_frame(-1, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp) begin errors++; $display("FAIL ur_frame1 got=%h exp=%h", dat, exp); end
      wait_fs(10, ok);
      checks++;
      if (!ok || underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse got fs=%b ur=%b exp fs=1 ur=1", frame_start, underrun); end
      fork
         capture_frame(-1, dat, lr, be, bu, fs, ur, r0, u0);
         begin
            repeat (20) @(negedge clk);
            offer(16'h4B2D, 16'hD2B4, 50, ok2);
         end
      join
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp) begin errors++; $display("FAIL ur_silent got=%h exp=%h", dat, exp); end
      checks++;
      if ({fs, ur, 31'd0, u0} !== {32'd1, 32'd1, 32'd1}) begin
         errors++; $display("FAIL ur_counts got fs=%0d ur=%0d ur0=%b exp 1 1 1", fs, ur, u0);
      end
      wait_fs(10, ok);
      capture_frame(0, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (!ok || dat !== exp || ur !== 0) begin
         errors++; $display("FAIL ur_recover got=%h ur=%0d exp=%h ur=0", dat, ur, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_bypass;
      logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL bypass_pre_ready got=%b exp=1", sample_ready); end
      left_data = 16'h3C3C; right_data = 16'hC3C3; sample_valid = 1'b1; enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sample_valid = 1'b0;
      sb.push_back({16'h3C3C, 16'hC3C3});
      checks++;
      if ({frame_start, underrun, sample_ready} !== 3'b101) begin
         errors++; $display("FAIL bypass_flags got fs/ur/rdy=%b exp=101", {frame_start, underrun, sample_ready});
      end
      capture_frame(0, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp || ur !== 0) begin errors++; $display("FAIL bypass_sdata got=%h ur=%0d exp=%h ur=0", dat, ur, exp); end
      @(negedge clk);
   endtask

   task automatic test_enable_drop;
      bit ok; logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      offer(16'hF00F, 16'h0FF0, 50, ok);
      enable = 1'b1;
      @(negedge clk);
      capture_frame(5, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp) begin errors++; $display("FAIL drop_sdata got=%h exp=%h", dat, exp); end
      checks++;
      if (bu !== 0 || be !== 0) begin errors++; $display("FAIL drop_full_frame got busy_err=%0d bclk_err=%0d exp 0 0", bu, be); end
      @(negedge clk);
      checks++;
      if ({busy, bclk, lrclk, sdata} !== 4'b0) begin
         errors++; $display("FAIL drop_idle got=%b exp=0000", {busy, bclk, lrclk, sdata});
      end
      offer(16'h1234, 16'h5F78, 10, ok);
      checks++;
      if (!ok || sample_ready !== 1'b0) begin errors++; $display("FAIL drop_accept got ok=%b rdy=%b exp ok=1 rdy=0", ok, sample_ready); end
   endtask

   task automatic test_reset_mid;
      bit ok; logic [31:0] dat, lr, exp; int be, bu, fs, ur; logic r0, u0;
      enable = 1'b1;
      wait_fs(10, ok);
      repeat (82) @(negedge clk);
      checks++;
      if (!ok || {bclk, lrclk, sdata, busy} !== 4'b1111) begin
         errors++; $display("FAIL rst_precond got=%b exp=1111", {bclk, lrclk, sdata, busy});
      end
      #2 rst_n = 1'b0; enable = 1'b0;
      #1;
      checks++;
      if ({bclk, lrclk, sdata, frame_start, underrun, busy, sample_ready} !== 7'b0000001) begin
         errors++; $display("FAIL rst_async got=%b exp=0000001", {bclk, lrclk, sdata, frame_start, underrun, busy, sample_ready});
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      offer(16'h6A6A, 16'h9595, 10, ok);
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if ({frame_start, underrun, lrclk, bclk} !== 4'b1000) begin
         errors++; $display("FAIL rst_restart got=%b exp=1000", {frame_start, underrun, lrclk, bclk});
      end
      capture_frame(0, dat, lr, be, bu, fs, ur, r0, u0);
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (dat !== exp || lr !== 32'h0001_FFFE) begin
         errors++; $display("FAIL rst_frame got=%h lr=%h exp=%h lr=0001fffe", dat, lr, exp);
      end
      @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset;
      test_preload;
      test_back_to_back;
      test_underrun;
      test_bypass;
      test_enable_drop;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog got=timeout exp=completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
